// File: rtl/axi_ram_slave.sv
// AXI4 slave backed by an on-chip dual-port word RAM with independent read and write engines.
// Optional WRAP burst support is enabled by defining AXI_RAM_WRAP_EN.
module axi_ram_slave #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // Write address channel
    input  logic [31:0] s_axi_awaddr_i,
    input  logic [7:0]  s_axi_awlen_i,
    input  logic [2:0]  s_axi_awsize_i,
    input  logic [1:0]  s_axi_awburst_i,
    input  logic        s_axi_awvalid_i,
    output logic        s_axi_awready_o,
    // Write data channel
    input  logic [31:0] s_axi_wdata_i,
    input  logic [3:0]  s_axi_wstrb_i,
    input  logic        s_axi_wlast_i,
    input  logic        s_axi_wvalid_i,
    output logic        s_axi_wready_o,
    // Write response channel
    output logic        s_axi_bid_o,
    output logic [1:0]  s_axi_bresp_o,
    output logic        s_axi_bvalid_o,
    input  logic        s_axi_bready_i,
    // Read address channel
    input  logic [31:0] s_axi_araddr_i,
    input  logic [7:0]  s_axi_arlen_i,
    input  logic [2:0]  s_axi_arsize_i,
    input  logic [1:0]  s_axi_arburst_i,
    input  logic        s_axi_arvalid_i,
    output logic        s_axi_arready_o,
    // Read data channel
    output logic        s_axi_rid_o,
    output logic [31:0] s_axi_rdata_o,
    output logic [1:0]  s_axi_rresp_o,
    output logic        s_axi_rlast_o,
    output logic        s_axi_rvalid_o,
    input  logic        s_axi_rready_i
);

    localparam int unsigned IdxW = $clog2(MEM_WORDS);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    localparam logic [33:0] MemBase = {2'b00, BASE_ADDR};
    localparam logic [33:0] MemEnd  = MemBase + 34'(MEM_WORDS) * 34'd4;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic [1:0] {RIdle, RFetch, RData} r_state_e;

    // Address-phase error check. INCR is monotonic, so checking first and last beat covers all
    // beats; a WRAP window is aligned and never larger than the RAM, so its start suffices.
    function automatic logic req_err(input logic [31:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
        logic [33:0] first;
        logic [33:0] last;
        logic        err;
        first = {2'b00, addr} & ~34'd3;
        last  = (burst == BurstIncr) ? first + {24'd0, len, 2'b00} : first;
        err   = (size != 3'b010) || (burst == 2'b11);
        err   = err || (first < MemBase) || (last >= MemEnd);
`ifdef AXI_RAM_WRAP_EN
        if (burst == BurstWrap) begin
            err = err || !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        end
`else
        if (burst == BurstWrap) begin
            err = 1'b1;
        end
`endif
        return err;
    endfunction

    // Wrap arithmetic is always computed; unsupported WRAP requests are flagged as errors, so
    // the resulting address is never used to touch RAM contents.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst,
                                              input logic [7:0] len);
        logic [31:0] mask;
        logic [31:0] nxt;
        mask = {22'd0, len, 2'b11};
        case (burst)
            BurstFixed: nxt = addr;
            BurstWrap:  nxt = (addr & ~mask) | ((addr + 32'd4) & mask);
            default:    nxt = addr + 32'd4;
        endcase
        return nxt;
    endfunction

    function automatic logic [IdxW-1:0] word_idx(input logic [31:0] addr);
        return IdxW'((addr - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] ram_rdata_q;
    logic        init_q;

    w_state_e    w_state_q, w_state_d;
    logic [31:0] waddr_q, waddr_d;
    logic [7:0]  wlen_q, wlen_d;
    logic [1:0]  wburst_q, wburst_d;
    logic        werr_q, werr_d;
    logic [8:0]  wcnt_q, wcnt_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        mem_we;

    r_state_e    r_state_q, r_state_d;
    logic [31:0] raddr_q, raddr_d;
    logic [7:0]  rlen_q, rlen_d;
    logic [1:0]  rburst_q, rburst_d;
    logic        rerr_q, rerr_d;
    logic [7:0]  rcnt_q, rcnt_d;
    logic        mem_re;

    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wburst_d  = wburst_q;
        werr_d    = werr_q;
        wcnt_d    = wcnt_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        s_axi_awready_o = init_q && (w_state_q == WIdle);
        s_axi_wready_o  = (w_state_q == WData);
        s_axi_bvalid_o  = (w_state_q == WResp);
        unique case (w_state_q)
            WIdle: begin
                if (s_axi_awvalid_i && s_axi_awready_o) begin
                    waddr_d   = s_axi_awaddr_i;
                    wlen_d    = s_axi_awlen_i;
                    wburst_d  = s_axi_awburst_i;
                    werr_d    = req_err(s_axi_awaddr_i, s_axi_awlen_i, s_axi_awsize_i,
                                        s_axi_awburst_i);
                    wcnt_d    = 9'd0;
                    w_state_d = WData;
                end
            end
            WData: begin
                if (s_axi_wvalid_i) begin
                    // Beats past AWLEN+1 are consumed but dropped.
                    mem_we  = !werr_q && (wcnt_q <= {1'b0, wlen_q});
                    waddr_d = next_addr(waddr_q, wburst_q, wlen_q);
                    if (wcnt_q != 9'h1FF) begin
                        wcnt_d = wcnt_q + 9'd1;
                    end
                    if (s_axi_wlast_i) begin
                        bresp_d = (werr_q || (wcnt_q != {1'b0, wlen_q})) ? RespSlvErr : RespOkay;
                        w_state_d = WResp;
                    end
                end
            end
            WResp: begin
                if (s_axi_bready_i) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rburst_d  = rburst_q;
        rerr_d    = rerr_q;
        rcnt_d    = rcnt_q;
        mem_re    = 1'b0;
        s_axi_arready_o = init_q && (r_state_q == RIdle);
        s_axi_rvalid_o  = (r_state_q == RData);
        s_axi_rlast_o   = (r_state_q == RData) && (rcnt_q == rlen_q);
        s_axi_rdata_o   = ((r_state_q == RData) && !rerr_q) ? ram_rdata_q : 32'd0;
        s_axi_rresp_o   = ((r_state_q == RData) && rerr_q) ? RespSlvErr : RespOkay;
        unique case (r_state_q)
            RIdle: begin
                if (s_axi_arvalid_i && s_axi_arready_o) begin
                    raddr_d   = s_axi_araddr_i;
                    rlen_d    = s_axi_arlen_i;
                    rburst_d  = s_axi_arburst_i;
                    rerr_d    = req_err(s_axi_araddr_i, s_axi_arlen_i, s_axi_arsize_i,
                                        s_axi_arburst_i);
                    rcnt_d    = 8'd0;
                    r_state_d = RFetch;
                end
            end
            RFetch: begin
                mem_re    = 1'b1;
                raddr_d   = next_addr(raddr_q, rburst_q, rlen_q);
                r_state_d = RData;
            end
            RData: begin
                // raddr_q already points at the next beat, so it is fetched on this handshake.
                if (s_axi_rready_i) begin
                    if (s_axi_rlast_o) begin
                        r_state_d = RIdle;
                    end else begin
                        mem_re  = 1'b1;
                        raddr_d = next_addr(raddr_q, rburst_q, rlen_q);
                        rcnt_d  = rcnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    assign s_axi_bid_o   = 1'b0;
    assign s_axi_rid_o   = 1'b0;
    assign s_axi_bresp_o = bresp_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            init_q    <= 1'b0;
            w_state_q <= WIdle;
            waddr_q   <= 32'd0;
            wlen_q    <= 8'd0;
            wburst_q  <= 2'b00;
            werr_q    <= 1'b0;
            wcnt_q    <= 9'd0;
            bresp_q   <= RespOkay;
            r_state_q <= RIdle;
            raddr_q   <= 32'd0;
            rlen_q    <= 8'd0;
            rburst_q  <= 2'b00;
            rerr_q    <= 1'b0;
            rcnt_q    <= 8'd0;
        end else begin
            init_q    <= 1'b1;
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wburst_q  <= wburst_d;
            werr_q    <= werr_d;
            wcnt_q    <= wcnt_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rburst_q  <= rburst_d;
            rerr_q    <= rerr_d;
            rcnt_q    <= rcnt_d;
        end
    end

    // RAM is not reset; the read port returns the pre-write value on a same-cycle collision.
    always_ff @(posedge clk_i) begin
        if (mem_we && rst_ni) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb_i[b]) begin
                    mem_q[word_idx(waddr_q)][8*b +: 8] <= s_axi_wdata_i[8*b +: 8];
                end
            end
        end
        if (mem_re && rst_ni) begin
            ram_rdata_q <= mem_q[word_idx(raddr_q)];
        end
    end

endmodule

// File: doc/axi_ram_slave.md
# axi_ram_slave

AXI4 memory-mapped responder with on-chip word RAM. It answers AR/R and AW/W/B transactions issued by the core's AXI master port, with independent read and write engines. It is the bus endpoint for simulation and for FPGA builds without external memory. It supports single-beat and INCR/FIXED bursts of 32-bit words, byte strobes and error responses.

## Interface
- MEM_WORDS, 4096: RAM depth in 32-bit words; power of two; ≥ 16.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to MEM_WORDS*4.
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset; synchronous, active-low.
- S_AXI_AWADDR in 32 / AWLEN in 8 / AWSIZE in 3 / AWBURST in 2 / AWVALID in 1 / AWREADY out 1: write address channel.
- S_AXI_WDATA in 32 / WSTRB in 4 / WLAST in 1 / WVALID in 1 / WREADY out 1: write data channel.
- S_AXI_BID out 1 (always 0) / BRESP out 2 / BVALID out 1 / BREADY in 1: write response channel.
- S_AXI_ARADDR in 32 / ARLEN in 8 / ARSIZE in 3 / ARBURST in 2 / ARVALID in 1 / ARREADY out 1: read address channel.
- S_AXI_RID out 1 (always 0) / RDATA out 32 / RRESP out 2 / RLAST out 1 / RVALID out 1 / RREADY in 1: read data channel.
- Masters without BREADY/RREADY tie these ports high.

## Operation
- RAM: dual-port. The write port and read port are used in the same cycle. The read port is read-first: a same-cycle write to the same word is seen on the next read.
- Word index = (addr − BASE_ADDR) >> 2. Low 2 address bits are ignored.
- Write FSM states: W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: AWREADY=1. On AWVALID&&AWREADY, latch addr, len, burst and error flag, then go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID&&WREADY beat writes the bytes whose WSTRB bit is 1.
    - INCR: address += 4 per beat. FIXED: address unchanged.
    - Beat counter counts up from 0.
    - On a beat with WLAST=1, go to W_RESP.
  - W_RESP: BVALID=1, BRESP held stable until BREADY. Then go to W_IDLE.
- Read FSM states: R_IDLE → R_FETCH → R_DATA → R_IDLE.
  - R_IDLE: ARREADY=1. On handshake, latch the request and go to R_FETCH.
  - R_FETCH: issue the RAM read for beat 0.
  - R_DATA: RVALID=1. RDATA/RRESP/RLAST held stable while !RREADY.
    - On RVALID&&RREADY, the next beat's read is already issued, so the next beat follows with no gap.
    - The beat with RLAST=1 is beat ARLEN. Its handshake returns to R_IDLE.
- Error (SLVERR 2'b10) conditions, evaluated at the address handshake:
  - SIZE ≠ 3'b010.
  - BURST = 2'b11.
  - Any beat address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*4).
  - Unsupported WRAP (see Configuration).
- Error effects:
  - Erroneous write: beats are accepted but not written; BRESP=SLVERR.
  - Erroneous read: RDATA=0 on all beats, RRESP=SLVERR, full ARLEN+1 beats with a correct RLAST.
- WLAST beat count ≠ AWLEN+1: BRESP=SLVERR. Beats past AWLEN+1 are not written.
- Otherwise BRESP/RRESP = OKAY (2'b00).

## Timing
- Reset (RST=0 at an edge):
  - AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0.
  - BRESP, RRESP, RDATA = 0.
  - Both FSMs return to idle.
  - RAM contents are retained.
  - This applies mid-transaction; the in-flight burst is abandoned and no response is issued.
- AWREADY/ARREADY rise on the first edge after reset release.
- Write: AW handshake at edge n gives WREADY=1 from n+1. WLAST beat at edge m gives BVALID=1 from m+1. With BREADY=1, AWREADY=1 again from m+2.
- Read: AR handshake at edge n gives RVALID=1 from n+2. With RREADY held high, an (L+1)-beat burst ends at edge n+2+L. ARREADY=1 from the next cycle.
- Read and write FSMs never stall each other.
- AWLEN=255 INCR: 256 beats. The address counter is 32-bit with no wrap at the 4 KB boundary; beats crossing the RAM end are flagged at the handshake.

## Configuration
- AXI_RAM_WRAP_EN defined:
  - BURST=2'b10 is supported for LEN ∈ {1,3,7,15}.
  - Address wraps inside an aligned (LEN+1)*4-byte window.
  - Other LEN values give SLVERR.
- Not defined: every WRAP request gives SLVERR, handled as above.

## Test plan
- Single write then read:
  - AW 0x10, LEN 0, WDATA 0xDEADBEEF, WSTRB 4'hF → BRESP 0.
  - AR 0x10 → RDATA 0xDEADBEEF, RLAST=1, RVALID exactly 2 cycles after the AR handshake.
- Byte strobes: word 0x20 = 0x11223344; write 0xAABBCCDD with WSTRB 4'b0101 → read returns 0x11BB33DD.
- INCR burst with RREADY backpressure:
  - Write 4 beats at 0x100 with data 1..4.
  - Read LEN 3 with RREADY low every other cycle → data 1,2,3,4 in order, stable while stalled, RLAST only on beat 4.
- Errors:
  - AR at BASE_ADDR+MEM_WORDS*4 → RRESP 2'b10, RDATA 0.
  - AW with AWSIZE 3'b001 → BRESP 2'b10 and RAM unchanged.
  - Early WLAST on beat 2 of LEN 3 → BRESP 2'b10.
- Concurrency and reset:
  - Simultaneous AR and AW to 0x40 → both complete independently; the read returns the old value.
  - RST low mid-burst → all outputs 0 next cycle and ready again after release.
- WRAP, LEN 3 at 0x38:
  - With AXI_RAM_WRAP_EN: beat addresses 0x38, 0x3C, 0x30, 0x34.
  - Without: RRESP 2'b10 on all 4 beats.
